// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that writes a 64-bit {hi, lo} result.
// Define MDU_FAST_MULT_EN for a single-cycle array multiply; divide is always iterative.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic        hl_write_enable,
    output logic [63:0] hl_data
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, next_state, start_target;
    logic        is_div_r;
    logic [31:0] mag_a, mag_b;
    logic        sign_a, sign_b;
    logic [4:0]  count;
    logic [63:0] acc;

    logic        accept;
    logic        a_neg, b_neg;
    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic [63:0] acc_step;
    logic [63:0] prod_mag;
    logic [31:0] src_a_raw;
    logic [63:0] fix_result;

    // A new operation is taken from IDLE, or from DONE once write-back is not stalled.
    assign accept = start & ~flush & ((state == IDLE) | ((state == DONE) & ~hold));
    assign a_neg  = ~op[0] & src_a[31];
    assign b_neg  = ~op[0] & src_b[31];

`ifdef MDU_FAST_MULT_EN
    assign start_target = op[1] ? CALC : FIX;
    assign prod_mag     = 64'(mag_a) * 64'(mag_b);
`else
    assign start_target = CALC;
    assign prod_mag     = acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (accept) next_state = start_target;
            CALC: if (count == 5'd31) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: begin
                if (accept)     next_state = start_target;
                else if (!hold) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // Multiply shifts the multiplier out of acc[31:0] while the product grows in
    // from the top; divide shifts the dividend out of the quotient half into the
    // remainder half. The 33-bit difference never overflows because the shifted
    // remainder is always below twice the divisor, so bit 32 is a true borrow.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag_a : 32'd0)};
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, mag_b};
        acc_step  = {mul_sum, acc[31:1]};
        if (is_div_r) begin
            if (div_diff[32]) acc_step = {div_shift[31:0], acc[30:0], 1'b0};
            else              acc_step = {div_diff[31:0],  acc[30:0], 1'b1};
        end
    end

    assign src_a_raw = sign_a ? -mag_a : mag_a;

    always_comb begin
        fix_result = 64'd0;
        if (!is_div_r)
            fix_result = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
        else if (mag_b == 32'd0)
            fix_result = {src_a_raw, 32'hFFFF_FFFF};
        else
            fix_result = {(sign_a ? -acc[63:32] : acc[63:32]),
                          ((sign_a ^ sign_b) ? -acc[31:0] : acc[31:0])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_r <= 1'b0;
            mag_a    <= 32'd0;
            mag_b    <= 32'd0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            count    <= 5'd0;
            acc      <= 64'd0;
            hl_data  <= 64'd0;
        end else begin
            if (accept) begin
                is_div_r <= op[1];
                mag_a    <= a_neg ? -src_a : src_a;
                mag_b    <= b_neg ? -src_b : src_b;
                sign_a   <= a_neg;
                sign_b   <= b_neg;
                count    <= 5'd0;
                acc      <= op[1] ? {32'd0, (a_neg ? -src_a : src_a)}
                                  : {32'd0, (b_neg ? -src_b : src_b)};
            end else if (state == CALC) begin
                count <= count + 5'd1;
                acc   <= acc_step;
            end
            if ((state == FIX) && !flush)
                hl_data <= fix_result;
        end
    end

    assign busy            = (state == CALC) | (state == FIX);
    assign done            = (state == DONE);
    assign hl_write_enable = done & ~hold & ~flush;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Table-driven bench for hilo_muldiv_unit with directed multi-cycle corner sequences.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush, hold;
    logic        busy, done, hl_write_enable;
    logic [63:0] hl_data;

    int total = 0;
    int bad   = 0;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expect_hl;
    } vec_t;

    vec_t vecs[13];

    hilo_muldiv_unit dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .src_a(src_a),
        .src_b(src_b),
        .flush(flush),
        .hold(hold),
        .busy(busy),
        .done(done),
        .hl_write_enable(hl_write_enable),
        .hl_data(hl_data)
    );

    always #5 clk = ~clk;

    // Every comparison funnels through here so the summary counts stay honest.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse; returns just after the sampling edge E0.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(output int edges, output int strobes);
        edges   = 0;
        strobes = 0;
        while (!done && edges < 100) begin
            tick();
            edges++;
            if (hl_write_enable) strobes++;
        end
    endtask

    initial begin
        int edges, strobes, lat;
        logic [63:0] prev;

        vecs[0]  = '{"multu_max",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{"mult_neg2x3", MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[2]  = '{"div_m7_2",    DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3]  = '{"divu_100_7",  DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E};
        vecs[4]  = '{"div_ovf",     DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[5]  = '{"divu_by0",    DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF};
        vecs[6]  = '{"div_neg_by0", DIV,   32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF};
        vecs[7]  = '{"mult_min2",   MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[8]  = '{"mult_7_m1",   MULT,  32'd7,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[9]  = '{"div_7_m2",    DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[10] = '{"multu_2p32",  MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[11] = '{"divu_max_1",  DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF};
        vecs[12] = '{"div_m8_m3",   DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'hFFFF_FFFE_0000_0002};

        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0; hold = 1'b0;
        tick();
        tick();
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_we",   64'(hl_write_enable), 64'd0);
        checkOutput("reset_data", hl_data, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput({vecs[i].name, "_busy"}, 64'(busy), 64'd1);
            waitDone(edges, strobes);
            lat = vecs[i].op[1] ? 33 : MUL_LAT;
            checkOutput({vecs[i].name, "_latency"}, 64'(edges), 64'(lat));
            checkOutput({vecs[i].name, "_data"}, hl_data, vecs[i].expect_hl);
            tick();
            if (hl_write_enable) strobes++;
            checkOutput({vecs[i].name, "_strobes"}, 64'(strobes), 64'd1);
            checkOutput({vecs[i].name, "_idle"}, 64'({busy, done}), 64'd0);
        end

        // Flush at count=10 cancels the divide without touching hl_data.
        prev = hl_data;
        applyStimulus(DIVU, 32'd100, 32'd7);
        for (int k = 0; k < 10; k++) tick();
        flush = 1'b1;
        checkOutput("flush_we_low", 64'(hl_write_enable), 64'd0);
        tick();
        flush = 1'b0;
        checkOutput("flush_idle", 64'({busy, done}), 64'd0);
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (hl_write_enable || busy) strobes++;
        end
        checkOutput("flush_no_activity", 64'(strobes), 64'd0);
        checkOutput("flush_data_kept", hl_data, prev);

        // start together with flush is dropped.
        start = 1'b1; flush = 1'b1; op = DIVU; src_a = 32'd9; src_b = 32'd2;
        tick();
        start = 1'b0; flush = 1'b0;
        checkOutput("start_flush_ignored", 64'(busy), 64'd0);

        // Hold DONE for 5 cycles, then release with a new start.
        hold = 1'b1;
        applyStimulus(MULTU, 32'd6, 32'd7);
        waitDone(edges, strobes);
        checkOutput("hold_no_strobe_early", 64'(strobes), 64'd0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("hold_done", 64'(done), 64'd1);
            checkOutput("hold_we", 64'(hl_write_enable), 64'd0);
            checkOutput("hold_data", hl_data, 64'd42);
            tick();
        end
        hold = 1'b0;
        op = DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        #1;
        checkOutput("release_we", 64'(hl_write_enable), 64'd1);
        tick();
        start = 1'b0;
        checkOutput("release_new_busy", 64'({busy, done, hl_write_enable}), 64'b100);
        waitDone(edges, strobes);
        checkOutput("release_new_latency", 64'(edges), 64'd33);
        checkOutput("release_new_data", hl_data, 64'h0000_0002_0000_000E);
        tick();

        // start while busy must not re-latch operands.
        applyStimulus(DIVU, 32'd100, 32'd7);
        for (int k = 0; k < 5; k++) tick();
        op = DIV; src_a = 32'hFFFF_FFF9; src_b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(edges, strobes);
        checkOutput("busy_start_latency", 64'(edges + 6), 64'd33);
        checkOutput("busy_start_data", hl_data, 64'h0000_0002_0000_000E);
        tick();
        checkOutput("busy_start_no_restart", 64'(busy), 64'd0);

        // Reset mid-divide clears everything and no strobe follows.
        applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2);
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_outputs", {hl_data[63:3], busy, done, hl_write_enable}, 64'd0);
        checkOutput("rst_mid_data", hl_data, 64'd0);
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (hl_write_enable) strobes++;
        end
        checkOutput("rst_mid_no_strobe", 64'(strobes), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide unit for the execute stage. It computes MULT/MULTU/DIV/DIVU and delivers a 64-bit {hi, lo} result, with a one-cycle write strobe, to the register file's hi/lo write-back port (`hl_data`, `hl_write_enable_from_wb`). It stalls the pipeline through `busy` while iterating, and is cancelled by the exception flush.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a new operation; sampled only when `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; latched with `start`.
- `src_a`  in  32  rs operand (multiplicand / dividend); latched with `start`.
- `src_b`  in  32  rt operand (multiplier / divisor); latched with `start`.
- `flush`  in  1  exception/eret cancel; aborts any operation.
- `hold`  in  1  write-back stall; result held while high.
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  high in DONE.
- `hl_write_enable`  out  1  `done & ~hold & ~flush`; the hi/lo write strobe.
- `hl_data`  out  64  result register {hi, lo}.

## Operation
- The FSM has four states: IDLE, CALC, FIX, DONE.
- IDLE or DONE leaving DONE, with `start`=1 and `flush`=0:
  - latch `op`;
  - latch operand magnitudes (absolute values for signed ops, raw for unsigned);
  - latch the sign flags;
  - `count`←0; go to CALC.
- CALC: one iteration per cycle; `count` increments; after iteration 31 (`count`=31), go to FIX.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: radix-2 restoring, with a 33-bit partial-remainder subtract.
- FIX: apply sign correction, register `hl_data`, go to DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- DONE: `done`=1.
  - `hold`=1: stay in DONE.
  - `hold`=0: leave to IDLE, or accept a new `start` on the same edge.
- Result format:
  - multiply: `hl_data` = full 64-bit product;
  - divide: `hl_data` = {remainder, quotient}.
- Divide by zero, any signedness: `hl_data` = {`src_a`, 32'hFFFF_FFFF}. It takes the normal latency and needs no special state.
- 0x8000_0000 / 0xFFFF_FFFF (DIV): quotient 0x8000_0000, remainder 0. This falls out of the magnitude arithmetic.
- `start` while `busy`=1: ignored; the operands are not re-latched.
- `flush`=1: on the next edge, go to IDLE from any state.
  - `hl_data` is not updated.
  - `hl_write_enable` is 0 in that cycle.
  - `flush` beats `start` on the same edge.
- Reset: state IDLE, `count`=0, `busy`=0, `done`=0, `hl_write_enable`=0, `hl_data`=0.

## Timing
- Let E0 be the edge that samples `start`.
- Iterative path:
  - CALC runs edges E1..E32;
  - FIX registers the result at E33;
  - `done`/`hl_write_enable` are high in the cycle after E33;
  - `busy` is high from after E0 until E33.
- Back-to-back operations: with `hold`=0 in DONE, a new `start` in that cycle is sampled. The unit accepts one operation per 34 cycles.
- `hl_write_enable` is high for exactly one cycle per operation when `hold`=0.
- Under `hold`, `hl_write_enable` rises in the first cycle `hold` is low; `hl_data` is stable throughout.
- `busy`, `done`, and `hl_data` are registered outputs. `hl_write_enable` is combinational from `done`, `hold`, and `flush`.
- Reset asserted mid-operation: all outputs are at their reset values after that edge, and no write strobe is issued.

## Configuration
- `MDU_FAST_MULT_EN` defined:
  - MULT/MULTU skip CALC and go from E0 straight to FIX.
  - FIX uses a single-cycle 32×32 array product, either signed or unsigned.
  - `done` is high in the cycle after E1.
  - Divide is unchanged at 33 cycles.
- Not defined: multiply uses the 32-iteration shift-add path and has the same latency as divide. Results are bit-identical in both builds.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → `hl_data`=0xFFFF_FFFE_0000_0001 with a single `hl_write_enable` pulse; latency 33 cycles (1 if `MDU_FAST_MULT_EN`).
- MULT 0xFFFF_FFFE (−2) × 3 → 0xFFFF_FFFF_FFFF_FFFA. DIV −7 / 2 → {0xFFFF_FFFF, 0xFFFF_FFFD}. DIVU 100 / 7 → {2, 14}.
- DIV 0x8000_0000 / 0xFFFF_FFFF → {0, 0x8000_0000}. DIVU 5 / 0 → {5, 0xFFFF_FFFF}.
- Flush mid-CALC (count=10) → IDLE on the next edge; no strobe; `hl_data` retains its prior value. Assert `start`+`flush` together → ignored.
- Hold the DONE state 5 cycles → `done`=1 throughout, `hl_write_enable`=0, data stable. Release `hold` with a new `start` → one strobe, and the new operation begins the same edge.
- Pulse `start` while busy with different operands → the first result is unaffected. Assert `rst` mid-DIV → all outputs 0 next cycle.
